// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction source for the 8-bit CPU. Holds program memory,
//                runs the PC and presents {op, imm} over a valid/ready
//                handshake. Resolves JMP/JNC locally using the ALU carry.
//                Program memory is byte-loaded while execution is stopped.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int         ADDR_W = 4,
    parameter logic [3:0] JMP_OP = 4'hF,
    parameter logic [3:0] JNC_OP = 4'hE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              halt_req,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic [3:0]        op,
    output logic [3:0]        imm,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              carry,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        state
);

    localparam int          c_depth = 1 << ADDR_W;
    localparam [ADDR_W-1:0] c_pc_one = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        HALT  = 2'b11
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [3:0]        r_op;
    logic [3:0]        r_imm;
    logic              r_valid;
    logic [7:0]        r_mem [c_depth];

    logic              w_ld_ready;
    logic              w_ld_we;
    logic              w_take_jump;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_next_pc;

    // Jump target: immediate adapted to the PC width (zero-extend or truncate)
    generate
        if (ADDR_W > 4) begin : g_tgt_ext
            assign w_target = {{(ADDR_W-4){1'b0}}, r_imm};
        end else if (ADDR_W == 4) begin : g_tgt_eq
            assign w_target = r_imm;
        end else begin : g_tgt_trunc
            assign w_target = r_imm[ADDR_W-1:0];
        end
    endgenerate

    // Load port only open while execution is stopped
    assign w_ld_ready = (r_state == IDLE) || (r_state == HALT);
    assign w_ld_we    = ld_valid && w_ld_ready;

    // Branch resolution on the instruction currently presented
    assign w_take_jump = (r_op == JMP_OP) || ((r_op == JNC_OP) && !carry);
    assign w_next_pc   = w_take_jump ? w_target : (r_pc + c_pc_one);

    // Program memory write port (contents survive reset)
    always_ff @(posedge clk) begin
        if (w_ld_we) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    // Fetch FSM: PC sequencing, registered memory read and handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_op    <= '0;
            r_imm   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    r_valid <= 1'b0;
                    if (run) begin
                        r_pc    <= '0;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (halt_req) begin
                        r_state <= HALT;
                    end else begin
                        {r_op, r_imm} <= r_mem[r_pc];
                        r_valid       <= 1'b1;
                        r_state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        // Accepted: advance PC even if a halt arrives with it
                        r_pc    <= w_next_pc;
                        r_valid <= 1'b0;
                        r_state <= halt_req ? HALT : FETCH;
                    end else if (halt_req) begin
                        // Discard the pending instruction, PC unchanged
                        r_valid <= 1'b0;
                        r_state <= HALT;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ld_ready    = w_ld_ready;
    assign op          = r_op;
    assign imm         = r_imm;
    assign instr_valid = r_valid;
    assign pc          = r_pc;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Directed self-checking bench for instr_fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic       clk;
    logic       reset;
    logic       run;
    logic       halt_req;
    logic       ld_valid;
    logic       ld_ready;
    logic [3:0] ld_addr;
    logic [7:0] ld_data;
    logic [3:0] op;
    logic [3:0] imm;
    logic       instr_valid;
    logic       instr_ready;
    logic       carry;
    logic [3:0] pc;
    logic [1:0] state;

    int n_pass;
    int n_total;

    instr_fetch #(
        .ADDR_W(4),
        .JMP_OP(4'hF),
        .JNC_OP(4'hE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .halt_req   (halt_req),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .op         (op),
        .imm        (imm),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .carry      (carry),
        .pc         (pc),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        step();
        ld_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        step();
        run = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_total++;
        if ({state, pc, op, imm, instr_valid, ld_ready} !== {2'b00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1})
            $display("FAIL reset_vals got st=%0h pc=%0h op=%0h imm=%0h v=%0b ldr=%0b want 0 0 0 0 0 1",
                     state, pc, op, imm, instr_valid, ld_ready);
        else n_pass++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_basic_program();
        logic [3:0] e_op  [5];
        logic [3:0] e_imm [5];
        logic [3:0] e_pc  [5];
        e_op  = '{4'h3, 4'h5, 4'h0, 4'hF, 4'h3};
        e_imm = '{4'h1, 4'h2, 4'h3, 4'h0, 4'h1};
        e_pc  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h0};
        load(4'd0, 8'h31);
        load(4'd1, 8'h52);
        load(4'd2, 8'h03);
        load(4'd3, 8'hF0);
        instr_ready = 1'b1;
        pulse_run();
        n_total++;
        if (instr_valid !== 1'b0 || state !== 2'b01 || pc !== 4'h0)
            $display("FAIL first_fetch got v=%0b st=%0h pc=%0h want v=0 st=1 pc=0", instr_valid, state, pc);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            step();
            n_total++;
            if ({instr_valid, op, imm, pc} !== {1'b1, e_op[k], e_imm[k], e_pc[k]})
                $display("FAIL basic_hold%0d got v=%0b op=%0h imm=%0h pc=%0h want v=1 op=%0h imm=%0h pc=%0h",
                         k, instr_valid, op, imm, pc, e_op[k], e_imm[k], e_pc[k]);
            else n_pass++;
            step();
            n_total++;
            if (instr_valid !== 1'b0 || state !== 2'b01)
                $display("FAIL basic_gap%0d got v=%0b st=%0h want v=0 st=1", k, instr_valid, state);
            else n_pass++;
        end
        // After JMP 0 the pc returned to 0 before the 5th instruction
        do_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_jnc();
        load(4'd0, 8'hF4);
        load(4'd4, 8'hE9);
        instr_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            carry = 1'b0;
            pulse_run();
            step();             // HOLD: JMP 4
            step();             // FETCH pc=4
            step();             // HOLD: JNC 9
            n_total++;
            if ({op, imm, pc} !== {4'hE, 4'h9, 4'h4})
                $display("FAIL jnc_present got op=%0h imm=%0h pc=%0h want E 9 4", op, imm, pc);
            else n_pass++;
            carry = (pass == 0);
            step();
            n_total++;
            if (pass == 0 && pc !== 4'h5)
                $display("FAIL jnc_carry1 got pc=%0h want 5", pc);
            else if (pass == 1 && pc !== 4'h9)
                $display("FAIL jnc_carry0 got pc=%0h want 9", pc);
            else n_pass++;
            carry = 1'b0;
            do_reset();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stall();
        load(4'd0, 8'h31);
        instr_ready = 1'b0;
        pulse_run();
        step();
        for (int c = 0; c < 5; c++) begin
            step();
            n_total++;
            if ({instr_valid, op, imm, pc, state} !== {1'b1, 4'h3, 4'h1, 4'h0, 2'b10})
                $display("FAIL stall%0d got v=%0b op=%0h imm=%0h pc=%0h st=%0h want 1 3 1 0 2",
                         c, instr_valid, op, imm, pc, state);
            else n_pass++;
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        step();
        n_total++;
        if (pc !== 4'h1 || state !== 2'b10)
            $display("FAIL stall_release got pc=%0h st=%0h want pc=1 st=2", pc, state);
        else n_pass++;
        do_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_wrap();
        for (int i = 0; i < 16; i++)
            load(4'(i), (i == 15) ? 8'h00 : {4'h1, 4'(i)});
        instr_ready = 1'b1;
        pulse_run();
        for (int i = 0; i < 16; i++) begin
            step();
            n_total++;
            if ({op, imm, pc} !== ((i == 15) ? {4'h0, 4'h0, 4'hF} : {4'h1, 4'(i), 4'(i)}))
                $display("FAIL wrap_seq%0d got op=%0h imm=%0h pc=%0h", i, op, imm, pc);
            else n_pass++;
            step();
        end
        n_total++;
        if (pc !== 4'h0 || state !== 2'b01)
            $display("FAIL wrap_pc got pc=%0h st=%0h want pc=0 st=1", pc, state);
        else n_pass++;
        do_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_halt();
        // memory holds the wrap program: mem[i] = {1, i}
        instr_ready = 1'b1;
        pulse_run();
        step();                         // HOLD pc0
        halt_req = 1'b1;
        step();                         // handshake + halt
        halt_req = 1'b0;
        n_total++;
        if ({state, pc, instr_valid, ld_ready} !== {2'b11, 4'h1, 1'b0, 1'b1})
            $display("FAIL halt_hs got st=%0h pc=%0h v=%0b ldr=%0b want 3 1 0 1",
                     state, pc, instr_valid, ld_ready);
        else n_pass++;
        instr_ready = 1'b0;
        pulse_run();                    // restart from 0
        step();                         // HOLD pc0, no ready
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        n_total++;
        if ({state, pc, instr_valid} !== {2'b11, 4'h0, 1'b0})
            $display("FAIL halt_nohs got st=%0h pc=%0h v=%0b want 3 0 0", state, pc, instr_valid);
        else n_pass++;
        // load attempts while running must be ignored
        pulse_run();
        n_total++;
        if (ld_ready !== 1'b0)
            $display("FAIL ld_ready_run got %0b want 0", ld_ready);
        else n_pass++;
        ld_valid = 1'b1;
        ld_addr  = 4'd1;
        ld_data  = 8'hAA;
        step();                         // HOLD pc0
        instr_ready = 1'b1;
        step();                         // FETCH pc1
        step();                         // HOLD pc1
        ld_valid = 1'b0;
        n_total++;
        if ({op, imm, pc} !== {4'h1, 4'h1, 4'h1})
            $display("FAIL ld_ignored got op=%0h imm=%0h pc=%0h want 1 1 1", op, imm, pc);
        else n_pass++;
        do_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        instr_ready = 1'b1;
        pulse_run();
        step();
        step();
        step();                         // HOLD pc1
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_total++;
        if ({state, pc, instr_valid, op} !== {2'b00, 4'h0, 1'b0, 4'h0})
            $display("FAIL reset_mid got st=%0h pc=%0h v=%0b op=%0h want 0 0 0 0",
                     state, pc, instr_valid, op);
        else n_pass++;
        pulse_run();
        step();
        n_total++;
        if ({instr_valid, op, imm, pc} !== {1'b1, 4'h1, 4'h0, 4'h0})
            $display("FAIL rerun0 got v=%0b op=%0h imm=%0h pc=%0h want 1 1 0 0", instr_valid, op, imm, pc);
        else n_pass++;
        step();
        step();
        n_total++;
        if ({instr_valid, op, imm, pc} !== {1'b1, 4'h1, 4'h1, 4'h1})
            $display("FAIL rerun1 got v=%0b op=%0h imm=%0h pc=%0h want 1 1 1 1", instr_valid, op, imm, pc);
        else n_pass++;
        do_reset();
    endtask

    // ------------------------------------------------------------------
    initial begin
        n_pass      = 0;
        n_total     = 0;
        reset       = 1'b1;
        run         = 1'b0;
        halt_req    = 1'b0;
        ld_valid    = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        instr_ready = 1'b0;
        carry       = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_program();
        test_jnc();
        test_stall();
        test_wrap();
        test_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
